load_store_period_monitor: RTL and testbench

- Downstream consumer of the load/store volume stage's full-level flag `sig`.
- Measures the period between successive full-level rising edges and checks each period against an expected value.
- Queues one result record per period in a small show-ahead FIFO with a valid/ready output.
- Drives a lock indicator and a sticky stall alarm for system supervision.

---
 rtl/load_store_period_monitor_if.sv | 12 +
 rtl/load_store_period_monitor.sv | 165 ++++++++++++++++
 tb/tb_load_store_period_monitor.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/load_store_period_monitor_if.sv
// Result-record handshake between the period monitor and its consumer.
interface load_store_period_monitor_if #(
  parameter int unsigned PBITS = 12
) ();
  logic             evt_valid;
  logic             evt_ready;
  logic [PBITS-1:0] evt_period;
  logic             evt_err;

  modport master (output evt_valid, output evt_period, output evt_err, input evt_ready);
  modport slave  (input evt_valid, input evt_period, input evt_err, output evt_ready);
endinterface

// File: rtl/load_store_period_monitor.sv
// Measures periods between rising edges of the full-level flag, queues checked records.
// Optional PM_ERR_COUNT_EN adds a saturating count of out-of-tolerance records.
module load_store_period_monitor #(
  parameter int unsigned EXP_PERIOD = 2502,
  parameter int unsigned TOL        = 0,
  parameter int unsigned PBITS      = 12,
  parameter int unsigned DEPTH      = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  load_store_period_monitor_if.master evt,
  output logic locked,
  output logic alarm,
  output logic ovf
`ifdef PM_ERR_COUNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [PBITS-1:0] CNT_MAX = '1;
  localparam logic [PBITS-1:0] CNT_PRE = CNT_MAX - PBITS'(1);
  localparam logic [PBITS:0]   EXP_W   = (PBITS+1)'(EXP_PERIOD);
  localparam logic [PBITS:0]   TOL_W   = (PBITS+1)'(TOL);

  typedef enum logic [1:0] {WAIT_FIRST, MEASURE, STALLED} state_e;

  state_e           state_q, state_d;
  logic             sig_q;
  logic [PBITS-1:0] cnt_q, cnt_d;
  logic             locked_q, locked_d;
  logic             prev_ok_q, prev_ok_d;
  logic             alarm_q, alarm_d;
  logic             ovf_q;
  logic             rise_c, rec_push_c, rec_err_c, out_tol_c;
  logic [PBITS:0]   cnt_w_c, dev_c;

  logic [AW:0]      wr_q, rd_q;
  logic [PBITS-1:0] per_mem [DEPTH];
  logic             err_mem [DEPTH];
  logic             empty_c, full_c, pop_c, wr_en_c, drop_c;

  assign rise_c    = sig_in & ~sig_q;
  // Deviation is taken one bit wider than the counter so it never wraps
  assign cnt_w_c   = {1'b0, cnt_q};
  assign dev_c     = (cnt_w_c >= EXP_W) ? (cnt_w_c - EXP_W) : (EXP_W - cnt_w_c);
  assign out_tol_c = dev_c > TOL_W;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_FIRST;
      sig_q     <= 1'b0;
      cnt_q     <= '0;
      locked_q  <= 1'b0;
      prev_ok_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_in;
      cnt_q     <= cnt_d;
      locked_q  <= locked_d;
      prev_ok_q <= prev_ok_d;
      alarm_q   <= alarm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alarm_d    = alarm_q;
    locked_d   = locked_q;
    prev_ok_d  = prev_ok_q;
    rec_push_c = 1'b0;
    rec_err_c  = out_tol_c;
    unique case (state_q)
      WAIT_FIRST: begin
        if (rise_c) begin
          cnt_d   = PBITS'(1);
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (rise_c) begin
          rec_push_c = 1'b1;
          cnt_d      = PBITS'(1);
        end else if (cnt_q == CNT_PRE) begin
          cnt_d     = CNT_MAX;
          state_d   = STALLED;
          alarm_d   = 1'b1;
          locked_d  = 1'b0;
          prev_ok_d = 1'b0;
        end else begin
          cnt_d = cnt_q + PBITS'(1);
        end
      end
      STALLED: begin
        if (rise_c) begin
          rec_push_c = 1'b1;
          rec_err_c  = 1'b1;
          cnt_d      = PBITS'(1);
          state_d    = MEASURE;
        end
      end
      default: state_d = WAIT_FIRST;
    endcase
    // Lock needs two in-tolerance records in a row; any bad record unlocks
    if (rec_push_c) begin
      if (rec_err_c) begin
        locked_d  = 1'b0;
        prev_ok_d = 1'b0;
      end else begin
        if (prev_ok_q) locked_d = 1'b1;
        prev_ok_d = 1'b1;
      end
    end
  end

  assign empty_c = (wr_q == rd_q);
  assign full_c  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_c   = ~empty_c & evt.evt_ready;
  assign wr_en_c = rec_push_c & (~full_c | pop_c);
  assign drop_c  = rec_push_c & full_c & ~pop_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_en_c) wr_q <= wr_q + (AW+1)'(1);
      if (pop_c)   rd_q <= rd_q + (AW+1)'(1);
      if (drop_c)  ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      per_mem[wr_q[AW-1:0]] <= cnt_q;
      err_mem[wr_q[AW-1:0]] <= rec_err_c;
    end
  end

  assign evt.evt_valid  = ~empty_c;
  assign evt.evt_period = empty_c ? '0 : per_mem[rd_q[AW-1:0]];
  assign evt.evt_err    = empty_c ? 1'b0 : err_mem[rd_q[AW-1:0]];
  assign locked         = locked_q;
  assign alarm          = alarm_q;
  assign ovf            = ovf_q;

`ifdef PM_ERR_COUNT_EN
  // Counts every bad record offered to the queue, including dropped ones
  logic [7:0] err_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (rec_push_c && rec_err_c && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_load_store_period_monitor.sv
// Randomized scoreboard bench for load_store_period_monitor against a cycle-count reference model.
module tb_load_store_period_monitor;
  localparam int EXP   = 2502;
  localparam int TOLV  = 0;
  localparam int PB    = 12;
  localparam int DEPTH = 4;
  localparam int MAXC  = 4095;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig_in = 1'b0;
  logic locked, alarm, ovf;
`ifdef PM_ERR_COUNT_EN
  logic [7:0] err_cnt;
`endif

  always #5 clk = ~clk;

  load_store_period_monitor_if #(.PBITS(PB)) evt_if ();

  load_store_period_monitor #(
    .EXP_PERIOD(EXP), .TOL(TOLV), .PBITS(PB), .DEPTH(DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .evt    (evt_if),
    .locked (locked),
    .alarm  (alarm),
    .ovf    (ovf)
`ifdef PM_ERR_COUNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  typedef struct {
    int period;
    bit err;
  } rec_t;

  rec_t sb[$];
  int total = 0;
  int bad   = 0;

  // Reference model: elapsed cycles since the last counted rising edge
  int cyc = 0;
  bit started = 0;
  int tlast = 0;
  bit prev_sig = 0;
  int ok_run = 0;
  bit alarm_m = 0;
  bit ovf_m = 0;
  int m_occ = 0;
  int errc_m = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    started = 0; tlast = 0; prev_sig = 0; ok_run = 0;
    alarm_m = 0; ovf_m = 0; m_occ = 0; errc_m = 0;
    sb.delete();
  endtask

  // One clock: check flags registered at this edge, then apply inputs and advance the model
  task automatic step(input bit s, input bit r, input bit rs);
    bit pop, rise, e;
    int d, p, dev;
    @(posedge clk);
    #1;
    chk("evt_valid", int'(evt_if.evt_valid), int'(m_occ > 0));
    chk("locked", int'(locked), int'(ok_run >= 2));
    chk("alarm", int'(alarm), int'(alarm_m));
    chk("ovf", int'(ovf), int'(ovf_m));
`ifdef PM_ERR_COUNT_EN
    chk("err_cnt", int'(err_cnt), errc_m);
`endif
    sig_in = s;
    evt_if.evt_ready = r;
    rst = rs;
    if (rs) begin
      model_reset();
    end else begin
      pop  = (m_occ > 0) && r;
      rise = s && !prev_sig;
      prev_sig = s;
      if (rise) begin
        if (started) begin
          d = cyc - tlast;
          p = (d >= MAXC) ? MAXC : d;
          dev = (p > EXP) ? (p - EXP) : (EXP - p);
          e = (d >= MAXC) || (dev > TOLV);
          ok_run = e ? 0 : ok_run + 1;
          if (e && errc_m < 255) errc_m++;
          if (m_occ == DEPTH && !pop) begin
            ovf_m = 1;
          end else begin
            sb.push_back('{p, e});
            m_occ++;
          end
        end
        started = 1;
        tlast = cyc;
      end else if (started && (cyc + 1 - tlast) >= MAXC) begin
        alarm_m = 1;
        ok_run = 0;
      end
      if (pop) m_occ--;
    end
    cyc++;
  endtask

  function automatic bit rdy(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return $urandom_range(0, 3) != 0;
  endfunction

  // Rising edge now, held high for width cycles, next edge after gap cycles
  task automatic period(input int gap, input int width, input int rmode);
    for (int i = 0; i < gap; i++) step(i < width, rdy(rmode), 1'b0);
  endtask

  // Monitor: compare the FIFO head whenever the DUT presents a record
  always @(negedge clk) begin
    if (!rst && evt_if.evt_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL evt_extra: got period %0d with no record expected", evt_if.evt_period);
      end else begin
        chk("evt_period", int'(evt_if.evt_period), sb[0].period);
        chk("evt_err", int'(evt_if.evt_err), int'(sb[0].err));
        if (evt_if.evt_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    int g;
    evt_if.evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
    // nominal lock, tolerance miss, wide pulses, neighbours of the expected period
    period(2502, 1, 1);
    period(2502, 1, 1);
    period(2503, 1, 1);
    period(2502, 2, 1);
    period(2502, 2, 1);
    period(2501, 3, 2);
    for (int k = 0; k < 3; k++) period(2501 + $urandom_range(0, 2), $urandom_range(1, 3), 2);
    // short random periods exercise queue occupancy under random backpressure
    for (int k = 0; k < 300; k++) begin
      g = $urandom_range(2, 40);
      period(g, $urandom_range(1, (g > 3) ? 3 : g - 1), 2);
    end
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b0);
    // counter saturation around the limit
    period(4094, 1, 1);
    period(4095, 1, 1);
    period(4300, 1, 1);
    period(2502, 1, 1);
    // backpressure: queue fills, later records dropped
    for (int k = 0; k < 6; k++) period(2502, 1, 0);
    period(2502, 1, 1);
    // reset with records queued
    for (int k = 0; k < 3; k++) period(2502, 1, 0);
    step(1'b0, 1'b0, 1'b1);
    period(2502, 1, 1);
    period(2502, 2, 1);
    period(2502, 1, 1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
